// File: rtl/hex_disp_pkg.sv
// Shared definitions for the 6-digit display chain: digit count, largest
// displayable value, load presets and the auto-repeat state encoding.
package hex_disp_pkg;

  localparam int          DISP_DIGITS = 6;
  localparam int unsigned DISP_MAX    = 999999;

  localparam int unsigned PRESET_VAL [4] = '{123456, 654321, 666666, 995461};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  // Preset lookup by the 2-bit select used on the load key.
  function automatic int unsigned preset_value(input logic [1:0] sel);
    return PRESET_VAL[sel];
  endfunction

endpackage

// File: rtl/key_filter.sv
// key_filter: synchronizes one raw active-low push-button, debounces it and
// emits a one-cycle press pulse on the accepted released->pressed transition.
// A key that is already held when reset is released is not armed until it has
// been seen released, so it cannot fire a press until released and pressed again.
module key_filter #(
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic pressed,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [1:0]       sync_n;
  logic [1:0]       fill;
  logic             armed;
  logic [CNT_W-1:0] cnt;
  logic             raw_pressed;

  assign raw_pressed = ~sync_n[1];

  // Two-flop synchronizer; fill marks when sync_n[1] holds a real sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_n <= 2'b11;
      fill   <= 2'b00;
    end else begin
      sync_n <= {sync_n[0], key_n};
      fill   <= {fill[0], 1'b1};
    end
  end

  // Arm press detection once the key has been observed released after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      armed <= 1'b0;
    end else if (fill[1] && !raw_pressed) begin
      armed <= 1'b1;
    end
  end

  // Stability counter: accept a new level after DEBOUNCE_CYC differing cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      pressed <= 1'b0;
      press   <= 1'b0;
    end else begin
      press <= 1'b0;
      if (raw_pressed != pressed) begin
        if (cnt == CNT_LAST) begin
          cnt     <= '0;
          pressed <= raw_pressed;
          press   <= raw_pressed & armed;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/hex_value_ctrl.sv
// hex_value_ctrl: user-editable binary value feeding the binary-to-BCD stage.
// Up/down keys step with wrap-around in 0..MAX_VAL, the load key picks a preset.
// Build macro HEX_VALUE_CTRL_AUTO_REPEAT_EN adds hold-to-repeat stepping;
// without it every up/down press steps exactly once.
//
//   state  | meaning
//   IDLE   | no direction key being repeated
//   DELAY  | first step taken, waiting out the initial hold time
//   REPEAT | stepping once per repeat period while the key stays held
module hex_value_ctrl
  import hex_disp_pkg::*;
#(
  parameter int          WIDTH             = 20,
  parameter int unsigned MAX_VAL           = DISP_MAX,
  parameter int          DEBOUNCE_CYC      = 1000000,
  parameter int          REPEAT_DELAY_CYC  = 25000000,
  parameter int          REPEAT_PERIOD_CYC = 5000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_up_n,
  input  logic             key_dn_n,
  input  logic             key_ld_n,
  input  logic [1:0]       preset_sel,
  output logic [WIDTH-1:0] data,
  output logic             data_valid
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  logic up_lvl, up_ev;
  logic dn_lvl, dn_ev;
  logic ld_lvl, ld_ev;
  logic step_up, step_dn;

  logic [31:0]      preset_raw;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] inc_val;
  logic [WIDTH-1:0] dec_val;

  key_filter #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_up (
    .clk     (clk),
    .reset   (reset),
    .key_n   (key_up_n),
    .pressed (up_lvl),
    .press   (up_ev)
  );

  key_filter #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_dn (
    .clk     (clk),
    .reset   (reset),
    .key_n   (key_dn_n),
    .pressed (dn_lvl),
    .press   (dn_ev)
  );

  key_filter #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_ld (
    .clk     (clk),
    .reset   (reset),
    .key_n   (key_ld_n),
    .pressed (ld_lvl),
    .press   (ld_ev)
  );

  assign preset_raw = preset_value(preset_sel);

  // Candidate next values; presets above MAX_VAL are clamped so data stays in range.
  always_comb begin
    load_val = (preset_raw > MAX_VAL) ? MAX_W : WIDTH'(preset_raw);
    inc_val  = (data == MAX_W) ? '0 : data + WIDTH'(1);
    dec_val  = (data == '0) ? MAX_W : data - WIDTH'(1);
  end

`ifdef HEX_VALUE_CTRL_AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY_CYC > REPEAT_PERIOD_CYC) ?
                           REPEAT_DELAY_CYC : REPEAT_PERIOD_CYC;
  localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY_CYC - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD_CYC - 1);

  rpt_state_e       state_q, state_d;
  logic             dir_up_q, dir_up_d;
  logic [RPT_W-1:0] cnt_q, cnt_d;
  logic             abort;
  logic             unused_lvl;

  assign unused_lvl = ld_lvl;

  // Repeat state register: direction being held and hold-time counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      dir_up_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      dir_up_q <= dir_up_d;
      cnt_q    <= cnt_d;
    end
  end

  // Held key let go, opposite key pressed, or a load all end the repeat run.
  assign abort = ld_ev || (dir_up_q ? (!up_lvl || dn_lvl) : (!dn_lvl || up_lvl));

  // Next-state and step requests for the shared up/down repeat engine.
  always_comb begin
    state_d  = state_q;
    dir_up_d = dir_up_q;
    cnt_d    = cnt_q;
    step_up  = 1'b0;
    step_dn  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!ld_ev && (up_ev ^ dn_ev)) begin
          step_up  = up_ev;
          step_dn  = dn_ev;
          dir_up_d = up_ev;
          cnt_d    = '0;
          state_d  = DELAY;
        end
      end
      DELAY, REPEAT: begin
        if (abort) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == ((state_q == DELAY) ? DELAY_LAST : PERIOD_LAST)) begin
          step_up = dir_up_q;
          step_dn = !dir_up_q;
          cnt_d   = '0;
          state_d = REPEAT;
        end else begin
          cnt_d = cnt_q + RPT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end
`else
  logic unused_lvl;

  assign unused_lvl = ^{ld_lvl, up_lvl, dn_lvl,
                        32'(REPEAT_DELAY_CYC), 32'(REPEAT_PERIOD_CYC)};

  // One step per press; simultaneous up and down presses cancel.
  always_comb begin
    step_up = up_ev & ~dn_ev;
    step_dn = dn_ev & ~up_ev;
  end
`endif

  // Output register: load beats stepping; data_valid marks each new value.
  always_ff @(posedge clk) begin
    if (reset) begin
      data       <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (ld_ev) begin
        data       <= load_val;
        data_valid <= 1'b1;
      end else if (step_up) begin
        data       <= inc_val;
        data_valid <= 1'b1;
      end else if (step_dn) begin
        data       <= dec_val;
        data_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hex_value_ctrl.sv
// Scoreboard bench for hex_value_ctrl with short debounce/repeat timing.
module tb_hex_value_ctrl;

  localparam int WIDTH = 20;
  localparam int DEB   = 4;
  localparam int RDLY  = 20;
  localparam int RPER  = 5;
  localparam int MAXV  = 999999;
  localparam int LAT   = 2 + DEB + 1;

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             key_up_n = 1'b1;
  logic             key_dn_n = 1'b1;
  logic             key_ld_n = 1'b1;
  logic [1:0]       preset_sel = 2'd0;
  logic [WIDTH-1:0] data;
  logic             data_valid;

  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   model_val = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  hex_value_ctrl #(
    .WIDTH             (WIDTH),
    .MAX_VAL           (MAXV),
    .DEBOUNCE_CYC      (DEB),
    .REPEAT_DELAY_CYC  (RDLY),
    .REPEAT_PERIOD_CYC (RPER)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_up_n   (key_up_n),
    .key_dn_n   (key_dn_n),
    .key_ld_n   (key_ld_n),
    .preset_sel (preset_sel),
    .data       (data),
    .data_valid (data_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_val(input string tag, input int obs, input int exp);
    n_assert++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int next_up(input int v);
    return (v >= MAXV) ? 0 : v + 1;
  endfunction

  function automatic int next_dn(input int v);
    return (v <= 0) ? MAXV : v - 1;
  endfunction

  function automatic int preset_of(input int sel);
    case (sel)
      0:       return 123456;
      1:       return 654321;
      2:       return 666666;
      default: return 995461;
    endcase
  endfunction

  task automatic push_exp(input int v, input int c);
    exp_t e;
    e.val = v;
    e.cyc = c;
    sb_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Short press of one key (0=up, 1=down, 2=load); hold is below the repeat delay.
  task automatic single_press(input int which);
    int p;
    p = cyc;
    case (which)
      0: begin key_up_n = 1'b0; model_val = next_up(model_val); end
      1: begin key_dn_n = 1'b0; model_val = next_dn(model_val); end
      default: begin key_ld_n = 1'b0; model_val = preset_of(int'(preset_sel)); end
    endcase
    push_exp(model_val, p + LAT);
    tick(10);
    key_up_n = 1'b1;
    key_dn_n = 1'b1;
    key_ld_n = 1'b1;
    tick(12);
  endtask

  // Every data_valid pulse must match the oldest expected value and cycle.
  always @(negedge clk) begin
    if (!reset && data_valid) begin
      if (sb_q.size() == 0) begin
        chk_val("spurious_valid", int'(data), -1);
      end else begin
        mon_e = sb_q.pop_front();
        chk_val("data", int'(data), mon_e.val);
        chk_val("latency", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    int p;
    int last_chg;

    tick(3);
    chk_val("reset_data", int'(data), 0);
    chk_val("reset_valid", int'(data_valid), 0);
    reset = 1'b0;
    tick(5);

    // Load preset 3.
    preset_sel = 2'd3;
    single_press(2);
    chk_val("load_p3", int'(data), 995461);

    // Bouncing up key, then stable low: exactly one step.
    last_chg = cyc;
    for (int i = 0; i < 15; i++) begin
      key_up_n = ~key_up_n;
      last_chg = cyc;
      tick(2);
    end
    model_val = next_up(model_val);
    push_exp(model_val, last_chg + LAT);
    tick(8);
    key_up_n = 1'b1;
    tick(14);
    chk_val("bounce_step", int'(data), 995462);

    // Load preset 0 then hold up for 50 cycles.
    preset_sel = 2'd0;
    single_press(2);
    p = cyc;
    key_up_n = 1'b0;
    model_val = next_up(model_val);
    push_exp(model_val, p + LAT);
`ifdef HEX_VALUE_CTRL_AUTO_REPEAT_EN
    for (int t = p + LAT + RDLY; t <= p + 50 + 2 + DEB; t += RPER) begin
      model_val = next_up(model_val);
      push_exp(model_val, t);
    end
`endif
    tick(50);
    key_up_n = 1'b1;
    tick(15);
    chk_val("hold_up_final", int'(data), model_val);

    // Up and down together: cancel, no valid.
    key_up_n = 1'b0;
    key_dn_n = 1'b0;
    tick(40);
    chk_val("cancel_data", int'(data), model_val);
    key_up_n = 1'b1;
    key_dn_n = 1'b1;
    tick(12);

    // Reset while up is held in the repeat region.
    p = cyc;
    key_up_n = 1'b0;
    model_val = next_up(model_val);
    push_exp(model_val, p + LAT);
`ifdef HEX_VALUE_CTRL_AUTO_REPEAT_EN
    model_val = next_up(model_val);
    push_exp(model_val, p + LAT + RDLY);
`endif
    tick(30);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    model_val = 0;
    chk_val("reset_sb_empty", sb_q.size(), 0);
    chk_val("reset_mid_data", int'(data), 0);
    tick(40);
    chk_val("held_after_reset", int'(data), 0);
    key_up_n = 1'b1;
    tick(12);
    single_press(0);
    chk_val("repress_up", int'(data), 1);

    // Wrap-around in both directions.
    single_press(1);
    chk_val("down_to_zero", int'(data), 0);
    single_press(1);
    chk_val("wrap_down", int'(data), MAXV);
    single_press(0);
    chk_val("wrap_up", int'(data), 0);

    tick(5);
    chk_val("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
